cla_serial_adder: RTL



---
 rtl/cla_serial_adder_pkg.sv | 16 +
 rtl/cla_serial_adder_carry.sv | 16 +
 rtl/cla_serial_adder_pg.sv | 14 +
 rtl/cla_serial_adder.sv | 103 ++++++++++
 4 files changed

// File: rtl/cla_serial_adder_pkg.sv
// rtl/cla_serial_adder_pkg.sv - shared constants and types for the nibble-serial adder
package cla_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    // Sum bits of one nibble given propagate, generated carries and incoming carry.
    function automatic nibble_t nibble_sum(input nibble_t p, input nibble_t c, input logic ci);
        return p ^ {c[NIBBLE_W-2:0], ci};
    endfunction

endpackage

// File: rtl/cla_serial_adder_carry.sv
// rtl/cla_serial_adder_carry.sv - 4-bit lookahead carry generator
module carry_gen (
    input  logic       cin,
    input  logic [3:0] p,
    input  logic [3:0] g,
    output logic [3:0] c
);

    // Fully expanded lookahead terms so no carry ripples through c[i-1].
    assign c[0] = g[0] | (p[0] & cin);
    assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

endmodule

// File: rtl/cla_serial_adder_pg.sv
// rtl/cla_serial_adder_pg.sv - gate-level propagate/generate for one nibble
module pg_gen
    import cla_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    output logic [NIBBLE_W-1:0] p,
    output logic [NIBBLE_W-1:0] g
);

    assign p = a ^ b;
    assign g = a & b;

endmodule

// File: rtl/cla_serial_adder.sv
// rtl/cla_serial_adder.sv - multi-cycle adder processing one nibble per clock, LSN first
module cla_serial_adder
    import cla_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    logic [0:0]       state;
    logic [IW-1:0]    idx;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    nibble_t a_nib;
    nibble_t b_nib;
    nibble_t p;
    nibble_t g;
    nibble_t c;
    nibble_t s;

    assign a_nib = a_q[idx*NIBBLE_W +: NIBBLE_W];
    assign b_nib = b_q[idx*NIBBLE_W +: NIBBLE_W];

    pg_gen u_pg (
        .a (a_nib),
        .b (b_nib),
        .p (p),
        .g (g)
    );

    carry_gen u_carry (
        .cin (carry_q),
        .p   (p),
        .g   (g),
        .c   (c)
    );

    assign s = nibble_sum(p, c, carry_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx     <= '0;
                        sum     <= '0;
                        cout    <= 1'b0;
                        ovf     <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_RUN;
                    end
                end
                default: begin
                    sum[idx*NIBBLE_W +: NIBBLE_W] <= s;
                    carry_q <= c[NIBBLE_W-1];
                    if (idx == LAST) begin
                        // Overflow compares carry into the MSB with carry out of it.
                        cout  <= c[NIBBLE_W-1];
                        ovf   <= c[NIBBLE_W-2] ^ c[NIBBLE_W-1];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
